// File: rtl/dmem_arb_pkg.sv
// Shared types and constants for the data-memory arbiter.
package dmem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_e;

  localparam int unsigned REQ_CPU       = 0;
  localparam int unsigned REQ_LOAD      = 1;
  localparam int unsigned DEF_MEM_BYTES = 32;
  localparam int unsigned DEF_CNT_W     = 16;
  localparam int unsigned ADDR_W        = 32;
  localparam int unsigned DATA_W        = 32;

  // Word access must be aligned and lie entirely inside memory; full-width compare, no wrap.
  function automatic logic addr_err(input logic [ADDR_W-1:0] addr,
                                    input logic [ADDR_W-1:0] max_addr);
    return (addr[1:0] != 2'b00) || (addr > max_addr);
  endfunction

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin grant; holds the last-granted pointer.
module rr_arbiter2 (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] valid,
  input  logic       en,
  output logic [1:0] grant_c,
  output logic       gid_c
);

  logic last_q, last_d;

  // On a tie the requester that did not win last time is chosen.
  always_comb begin
    gid_c   = valid[1];
    grant_c = 2'b00;
    last_d  = last_q;
    if (valid == 2'b11) gid_c = ~last_q;
    if (en && (|valid)) begin
      grant_c = gid_c ? 2'b10 : 2'b01;
      last_d  = gid_c;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) last_q <= 1'b1;
    else     last_q <= last_d;
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Shares the data-memory port between the CPU LSU and the loader: accept, one-cycle access, response.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int unsigned MEM_BYTES = DEF_MEM_BYTES,
  parameter int unsigned CNT_W     = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       req_valid,
  output logic [1:0]       req_ready,
  input  logic [1:0]       req_we,
  input  logic [31:0]      req_addr0,
  input  logic [31:0]      req_addr1,
  input  logic [31:0]      req_wdata0,
  input  logic [31:0]      req_wdata1,
  output logic [1:0]       resp_valid,
  output logic             resp_err,
  output logic [31:0]      resp_rdata,
  output logic             mem_read,
  output logic             mem_write,
  output logic [31:0]      mem_addr,
  output logic [31:0]      mem_wdata,
  input  logic [31:0]      mem_rdata,
  output logic [CNT_W-1:0] grant_cnt0,
  output logic [CNT_W-1:0] grant_cnt1
);

  localparam logic [ADDR_W-1:0] MAX_ADDR = ADDR_W'(MEM_BYTES - 4);
  localparam logic [CNT_W-1:0]  CNT_MAX  = {CNT_W{1'b1}};

  state_e             state_q, state_d;
  logic               g_q, g_d;
  logic               we_q, we_d;
  logic               err_q, err_d;
  logic [31:0]        mem_addr_q, mem_addr_d;
  logic [31:0]        mem_wdata_q, mem_wdata_d;
  logic               mem_read_q, mem_read_d;
  logic               mem_write_q, mem_write_d;
  logic [1:0]         resp_valid_q, resp_valid_d;
  logic               resp_err_q, resp_err_d;
  logic [31:0]        resp_rdata_q, resp_rdata_d;
  logic [CNT_W-1:0]   cnt0_q, cnt0_d;
  logic [CNT_W-1:0]   cnt1_q, cnt1_d;

  logic [1:0]         grant_c;
  logic               gid_c;
  logic               arb_en_c;
  logic [31:0]        sel_addr_c;
  logic [31:0]        sel_wdata_c;
  logic               sel_we_c;
  logic               sel_err_c;

  // Ready is held low during reset even though the state register already reads IDLE.
  assign arb_en_c = (state_q == IDLE) && !rst;

  rr_arbiter2 u_rr (
    .clk     (clk),
    .rst     (rst),
    .valid   (req_valid),
    .en      (arb_en_c),
    .grant_c (grant_c),
    .gid_c   (gid_c)
  );

  assign req_ready   = grant_c;
  assign sel_addr_c  = (gid_c == 1'(REQ_CPU)) ? req_addr0 : req_addr1;
  assign sel_wdata_c = (gid_c == 1'(REQ_CPU)) ? req_wdata0 : req_wdata1;
  assign sel_we_c    = req_we[gid_c];
  assign sel_err_c   = addr_err(sel_addr_c, MAX_ADDR);

  always_comb begin
    state_d      = state_q;
    g_d          = g_q;
    we_d         = we_q;
    err_d        = err_q;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    cnt0_d       = cnt0_q;
    cnt1_d       = cnt1_q;
    mem_read_d   = 1'b0;
    mem_write_d  = 1'b0;
    resp_valid_d = 2'b00;
    resp_err_d   = 1'b0;
    resp_rdata_d = 32'h0;
    case (state_q)
      IDLE: begin
        if (|grant_c) begin
          state_d     = ACCESS;
          g_d         = gid_c;
          we_d        = sel_we_c;
          err_d       = sel_err_c;
          mem_addr_d  = sel_addr_c;
          mem_wdata_d = sel_wdata_c;
          mem_write_d = !sel_err_c && sel_we_c;
          mem_read_d  = !sel_err_c && !sel_we_c;
          if (gid_c == 1'(REQ_CPU)) begin
            if (cnt0_q != CNT_MAX) cnt0_d = cnt0_q + CNT_W'(1);
          end else begin
            if (cnt1_q != CNT_MAX) cnt1_d = cnt1_q + CNT_W'(1);
          end
        end
      end
      ACCESS: begin
        state_d      = RESP;
        resp_valid_d = g_q ? 2'b10 : 2'b01;
        resp_err_d   = err_q;
        resp_rdata_d = (!err_q && !we_q) ? mem_rdata : 32'h0;
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      g_q          <= 1'b0;
      we_q         <= 1'b0;
      err_q        <= 1'b0;
      mem_addr_q   <= 32'h0;
      mem_wdata_q  <= 32'h0;
      mem_read_q   <= 1'b0;
      mem_write_q  <= 1'b0;
      resp_valid_q <= 2'b00;
      resp_err_q   <= 1'b0;
      resp_rdata_q <= 32'h0;
      cnt0_q       <= '0;
      cnt1_q       <= '0;
    end else begin
      state_q      <= state_d;
      g_q          <= g_d;
      we_q         <= we_d;
      err_q        <= err_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      mem_read_q   <= mem_read_d;
      mem_write_q  <= mem_write_d;
      resp_valid_q <= resp_valid_d;
      resp_err_q   <= resp_err_d;
      resp_rdata_q <= resp_rdata_d;
      cnt0_q       <= cnt0_d;
      cnt1_q       <= cnt1_d;
    end
  end

  assign mem_read   = mem_read_q;
  assign mem_write  = mem_write_q;
  assign mem_addr   = mem_addr_q;
  assign mem_wdata  = mem_wdata_q;
  assign resp_valid = resp_valid_q;
  assign resp_err   = resp_err_q;
  assign resp_rdata = resp_rdata_q;
  assign grant_cnt0 = cnt0_q;
  assign grant_cnt1 = cnt1_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: directed scenarios plus randomized traffic against a word-level model.
module tb_dmem_arbiter;

  localparam int MEM_BYTES = 32;
  localparam int WORDS     = MEM_BYTES / 4;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  req_valid, req_ready, req_we, resp_valid;
  logic [31:0] req_addr0, req_addr1, req_wdata0, req_wdata1;
  logic        resp_err, mem_read, mem_write;
  logic [31:0] resp_rdata, mem_addr, mem_wdata, mem_rdata;
  logic [15:0] grant_cnt0, grant_cnt1;

  logic [1:0]  s_req_valid, s_req_ready, s_resp_valid;
  logic        s_resp_err, s_mem_read, s_mem_write;
  logic [31:0] s_resp_rdata, s_mem_addr, s_mem_wdata;
  logic [1:0]  s_grant_cnt0, s_grant_cnt1;

  int n_tests = 0;
  int n_fail  = 0;

  logic [31:0] mem [WORDS];
  logic [31:0] ref_mem [WORDS];
  logic        mem_clr;
  int          wr_pulses, rd_pulses, both_hi;
  logic [31:0] last_waddr;
  int          exp_cnt [2];

  always #5 clk = ~clk;

  dmem_arbiter #(.MEM_BYTES(MEM_BYTES), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr0(req_addr0), .req_addr1(req_addr1), .req_wdata0(req_wdata0), .req_wdata1(req_wdata1),
    .resp_valid(resp_valid), .resp_err(resp_err), .resp_rdata(resp_rdata),
    .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .grant_cnt0(grant_cnt0), .grant_cnt1(grant_cnt1)
  );

  dmem_arbiter #(.MEM_BYTES(MEM_BYTES), .CNT_W(2)) dut_sat (
    .clk(clk), .rst(rst), .req_valid(s_req_valid), .req_ready(s_req_ready), .req_we(2'b00),
    .req_addr0(32'h0), .req_addr1(32'h0), .req_wdata0(32'h0), .req_wdata1(32'h0),
    .resp_valid(s_resp_valid), .resp_err(s_resp_err), .resp_rdata(s_resp_rdata),
    .mem_read(s_mem_read), .mem_write(s_mem_write), .mem_addr(s_mem_addr), .mem_wdata(s_mem_wdata),
    .mem_rdata(32'h0), .grant_cnt0(s_grant_cnt0), .grant_cnt1(s_grant_cnt1)
  );

  function automatic logic [31:0] seed_word(input int i);
    return (32'(i) * 32'h0101_0101) ^ 32'hC3C3_5A5A;
  endfunction

  // Memory environment: combinational read, write committed on the clock edge.
  assign mem_rdata = mem_read ? mem[mem_addr[4:2]] : 32'h0;

  always @(posedge clk) begin
    if (mem_clr) begin
      for (int i = 0; i < WORDS; i++) mem[i] <= seed_word(i);
    end else if (mem_write && !rst) begin
      mem[mem_addr[4:2]] <= mem_wdata;
    end
  end

  always @(negedge clk) begin
    if (mem_write) begin
      wr_pulses++;
      last_waddr = mem_addr;
    end
    if (mem_read) rd_pulses++;
    if (mem_read && mem_write) both_hi++;
  end

  // Model rules for a single request.
  function automatic logic model_err(input logic [31:0] addr);
    return ((addr % 4) != 0) || (longint'(addr) > longint'(MEM_BYTES - 4));
  endfunction

  task automatic do_req(input int r, input logic we, input logic [31:0] addr, input logic [31:0] wd,
                        output logic [31:0] rd, output logic er, output logic [1:0] rv, output int lat);
    bit ok = 0;
    rd = 32'h0; er = 1'b0; rv = 2'b00; lat = -1;
    @(negedge clk);
    req_valid[r] = 1'b1;
    req_we[r]    = we;
    if (r == 0) begin req_addr0 = addr; req_wdata0 = wd; end
    else        begin req_addr1 = addr; req_wdata1 = wd; end
    for (int i = 0; i < 20; i++) begin
      #1;
      if (req_ready[r]) begin ok = 1; break; end
      @(negedge clk);
    end
    if (!ok) begin
      req_valid[r] = 1'b0;
      return;
    end
    @(posedge clk);
    #1;
    req_valid[r] = 1'b0;
    exp_cnt[r]++;
    wr_pulses = 0; rd_pulses = 0;
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      if (|resp_valid) begin
        rv = resp_valid; er = resp_err; rd = resp_rdata; lat = i;
        break;
      end
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    req_valid = 2'b11; req_we = 2'b00; req_addr0 = 32'h0; req_addr1 = 32'h4;
    #1;
    n_tests++; if (req_ready !== 2'b00) begin n_fail++; $display("FAIL reset_ready got %b want 00", req_ready); end
    n_tests++; if (resp_valid !== 2'b00) begin n_fail++; $display("FAIL reset_resp_valid got %b want 00", resp_valid); end
    n_tests++; if (resp_err !== 1'b0) begin n_fail++; $display("FAIL reset_resp_err got %b want 0", resp_err); end
    n_tests++; if (resp_rdata !== 32'h0) begin n_fail++; $display("FAIL reset_resp_rdata got %h want 0", resp_rdata); end
    n_tests++; if ({mem_read, mem_write} !== 2'b00) begin n_fail++; $display("FAIL reset_mem_en got %b want 00", {mem_read, mem_write}); end
    n_tests++; if (mem_addr !== 32'h0 || mem_wdata !== 32'h0) begin n_fail++; $display("FAIL reset_mem_bus got %h/%h want 0/0", mem_addr, mem_wdata); end
    n_tests++; if (grant_cnt0 !== 16'h0 || grant_cnt1 !== 16'h0) begin n_fail++; $display("FAIL reset_cnt got %0d/%0d want 0/0", grant_cnt0, grant_cnt1); end
  endtask

  // Both requesters held valid from reset release: grants alternate, one every three cycles.
  task automatic test_contention();
    int exp_last = 1;
    int busy = 0;
    int acc [2] = '{0, 0};
    logic [1:0] exp_ready;
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 12; i++) begin
      #1;
      exp_ready = 2'b00;
      if (busy == 0) begin
        exp_last  = 1 - exp_last;
        exp_ready = (exp_last == 1) ? 2'b10 : 2'b01;
        acc[exp_last]++;
        busy = 3;
      end
      n_tests++;
      if (req_ready !== exp_ready) begin
        n_fail++; $display("FAIL contention_ready cycle %0d got %b want %b", i, req_ready, exp_ready);
      end
      busy--;
      @(negedge clk);
    end
    req_valid = 2'b00;
    repeat (4) @(negedge clk);
    n_tests++; if (grant_cnt0 !== 16'(acc[0])) begin n_fail++; $display("FAIL contention_cnt0 got %0d want %0d", grant_cnt0, acc[0]); end
    n_tests++; if (grant_cnt1 !== 16'(acc[1])) begin n_fail++; $display("FAIL contention_cnt1 got %0d want %0d", grant_cnt1, acc[1]); end
    exp_cnt[0] = acc[0]; exp_cnt[1] = acc[1];
  endtask

  task automatic test_write_read();
    logic [31:0] rd; logic er; logic [1:0] rv; int lat;
    do_req(0, 1'b1, 32'd8, 32'hDEAD_BEEF, rd, er, rv, lat);
    ref_mem[2] = 32'hDEAD_BEEF;
    n_tests++; if (lat !== 2) begin n_fail++; $display("FAIL wr_latency got %0d want 2", lat); end
    n_tests++; if (wr_pulses !== 1 || rd_pulses !== 0) begin n_fail++; $display("FAIL wr_pulses got w%0d r%0d want w1 r0", wr_pulses, rd_pulses); end
    n_tests++; if (rv !== 2'b01 || er !== 1'b0 || rd !== 32'h0) begin n_fail++; $display("FAIL wr_resp got %b/%b/%h want 01/0/0", rv, er, rd); end
    do_req(0, 1'b0, 32'd8, 32'h0, rd, er, rv, lat);
    n_tests++; if (lat !== 2) begin n_fail++; $display("FAIL rd_latency got %0d want 2", lat); end
    n_tests++; if (rd !== 32'hDEAD_BEEF || er !== 1'b0) begin n_fail++; $display("FAIL rd_data got %h/%b want deadbeef/0", rd, er); end
    n_tests++; if (rd_pulses !== 1 || wr_pulses !== 0) begin n_fail++; $display("FAIL rd_pulses got r%0d w%0d want r1 w0", rd_pulses, wr_pulses); end
  endtask

  task automatic test_errors();
    logic [31:0] addrs [3] = '{32'd30, 32'd6, 32'hFFFF_FFFC};
    logic [31:0] rd; logic er; logic [1:0] rv; int lat;
    for (int k = 0; k < 3; k++) begin
      do_req(1, 1'b0, addrs[k], 32'h0, rd, er, rv, lat);
      n_tests++;
      if (rv !== 2'b10 || er !== 1'b1 || rd !== 32'h0 || lat !== 2) begin
        n_fail++; $display("FAIL err_resp addr %h got %b/%b/%h lat %0d want 10/1/0 lat 2", addrs[k], rv, er, rd, lat);
      end
      n_tests++;
      if (rd_pulses !== 0 || wr_pulses !== 0) begin
        n_fail++; $display("FAIL err_no_access addr %h got r%0d w%0d want 0/0", addrs[k], rd_pulses, wr_pulses);
      end
    end
  endtask

  task automatic test_last_legal();
    logic [31:0] rd; logic er; logic [1:0] rv; int lat;
    do_req(0, 1'b1, 32'd28, 32'hCAFE_F00D, rd, er, rv, lat);
    ref_mem[7] = 32'hCAFE_F00D;
    n_tests++; if (wr_pulses !== 1 || last_waddr !== 32'd28) begin n_fail++; $display("FAIL last_legal_write got %0d pulses addr %h want 1 addr 1c", wr_pulses, last_waddr); end
    n_tests++; if (er !== 1'b0 || rv !== 2'b01) begin n_fail++; $display("FAIL last_legal_resp got %b/%b want 01/0", rv, er); end
  endtask

  task automatic test_reset_mid();
    logic [31:0] rd; logic er; logic [1:0] rv; int lat;
    int resp_seen = 0;
    @(negedge clk);
    req_valid[0] = 1'b1; req_we[0] = 1'b1; req_addr0 = 32'd4; req_wdata0 = 32'h1234_5678;
    @(posedge clk);
    #1;
    req_valid[0] = 1'b0;
    n_tests++; if (mem_write !== 1'b1) begin n_fail++; $display("FAIL rstmid_inflight got mem_write %b want 1", mem_write); end
    #2;
    rst = 1'b1;
    #1;
    n_tests++;
    if (mem_write !== 1'b0 || mem_addr !== 32'h0 || mem_wdata !== 32'h0 || grant_cnt0 !== 16'h0) begin
      n_fail++; $display("FAIL rstmid_clear got w%b a%h d%h c%0d want all 0", mem_write, mem_addr, mem_wdata, grant_cnt0);
    end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    exp_cnt[0] = 0; exp_cnt[1] = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (|resp_valid) resp_seen++;
    end
    n_tests++; if (resp_seen !== 0) begin n_fail++; $display("FAIL rstmid_no_resp got %0d pulses want 0", resp_seen); end
    do_req(0, 1'b0, 32'd4, 32'h0, rd, er, rv, lat);
    n_tests++; if (rd !== ref_mem[1] || er !== 1'b0) begin n_fail++; $display("FAIL rstmid_readback got %h want %h", rd, ref_mem[1]); end
  endtask

  task automatic test_random();
    logic [31:0] rd, addr, wd, exp_rd; logic er, we, exp_er; logic [1:0] rv; int lat, r, kind;
    logic [31:0] far [4] = '{32'd32, 32'h0000_0100, 32'h8000_0000, 32'hFFFF_FFFC};
    for (int n = 0; n < 40; n++) begin
      r    = int'($urandom_range(0, 1));
      we   = 1'($urandom_range(0, 1));
      wd   = $urandom;
      kind = int'($urandom_range(0, 3));
      if (kind <= 1)      addr = 32'($urandom_range(0, WORDS - 1) * 4);
      else if (kind == 2) addr = 32'($urandom_range(0, WORDS - 1) * 4 + $urandom_range(1, 3));
      else                addr = far[$urandom_range(0, 3)];
      exp_er = model_err(addr);
      exp_rd = (exp_er || we) ? 32'h0 : ref_mem[addr / 4];
      do_req(r, we, addr, wd, rd, er, rv, lat);
      if (!exp_er && we) ref_mem[addr / 4] = wd;
      n_tests++;
      if (rv !== ((r == 1) ? 2'b10 : 2'b01) || er !== exp_er || rd !== exp_rd || lat !== 2) begin
        n_fail++;
        $display("FAIL rand_resp #%0d r%0d we%0d addr %h got %b/%b/%h lat %0d want err %b data %h lat 2",
                 n, r, we, addr, rv, er, rd, lat, exp_er, exp_rd);
      end
      n_tests++;
      if (wr_pulses !== int'(!exp_er && we) || rd_pulses !== int'(!exp_er && !we)) begin
        n_fail++; $display("FAIL rand_access #%0d got w%0d r%0d", n, wr_pulses, rd_pulses);
      end
    end
    n_tests++; if (grant_cnt0 !== 16'(exp_cnt[0]) || grant_cnt1 !== 16'(exp_cnt[1])) begin
      n_fail++; $display("FAIL rand_cnt got %0d/%0d want %0d/%0d", grant_cnt0, grant_cnt1, exp_cnt[0], exp_cnt[1]);
    end
    n_tests++; if (both_hi !== 0) begin n_fail++; $display("FAIL read_write_overlap got %0d want 0", both_hi); end
  endtask

  task automatic test_saturation();
    int accepts = 0;
    @(negedge clk);
    s_req_valid = 2'b01;
    for (int i = 0; i < 40 && accepts < 5; i++) begin
      #1;
      if (s_req_ready[0]) accepts++;
      @(negedge clk);
    end
    s_req_valid = 2'b00;
    repeat (4) @(negedge clk);
    n_tests++; if (accepts !== 5) begin n_fail++; $display("FAIL sat_accepts got %0d want 5", accepts); end
    n_tests++; if (s_grant_cnt0 !== 2'd3 || s_grant_cnt1 !== 2'd0) begin n_fail++; $display("FAIL sat_cnt got %0d/%0d want 3/0", s_grant_cnt0, s_grant_cnt1); end
  endtask

  initial begin
    rst = 1'b1; mem_clr = 1'b1;
    req_valid = 2'b00; req_we = 2'b00;
    req_addr0 = 32'h0; req_addr1 = 32'h0; req_wdata0 = 32'h0; req_wdata1 = 32'h0;
    s_req_valid = 2'b00;
    wr_pulses = 0; rd_pulses = 0; both_hi = 0; last_waddr = 32'h0;
    exp_cnt[0] = 0; exp_cnt[1] = 0;
    for (int i = 0; i < WORDS; i++) ref_mem[i] = seed_word(i);
    repeat (3) @(posedge clk);
    mem_clr = 1'b0;
    test_reset();
    test_contention();
    test_write_read();
    test_errors();
    test_last_legal();
    test_reset_mid();
    test_random();
    test_saturation();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
